// File: rtl/reg_scan_8x4_pkg.sv
// ============================================================================
// Module   : reg_scan_8x4_pkg
// Brief    : Shared constants, state encoding and write-decode helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_scan_8x4_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH     = 8;
  localparam int SEL_W     = 3;

  localparam logic [SEL_W-1:0] SEL_FIRST = 3'd0;
  localparam logic [SEL_W-1:0] SEL_PRE   = 3'd6;
  localparam logic [SEL_W-1:0] SEL_LAST  = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // One-hot write strobe per entry; all-zero when writes are disabled.
  function automatic logic [DEPTH-1:0] wr_decode(input logic en,
                                                 input logic [SEL_W-1:0] addr);
    logic [DEPTH-1:0] hit;
    hit = '0;
    if (en) hit[addr] = 1'b1;
    return hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scan_8x4_scan_ctrl.sv
// ============================================================================
// Module   : reg_scan_8x4_scan_ctrl
// Brief    : IDLE/SCAN sequencer stepping the mux select through 0..7.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_scan_8x4_scan_ctrl
  import reg_scan_8x4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_loop,
  input  logic             i_stop,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_busy,
  output logic             o_done
);

  scan_state_e      r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_busy;
  logic             r_done;

  // Busy/Done are registered alongside the next state so they carry no
  // combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= SEL_FIRST;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sel  <= SEL_FIRST;
          r_done <= 1'b0;
          if (i_start && !i_stop) begin
            r_state <= SCAN;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (i_stop) begin
            r_state <= IDLE;
            r_sel   <= SEL_FIRST;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (r_sel != SEL_LAST) begin
            r_sel   <= r_sel + SEL_W'(1);
            r_done  <= (r_sel == SEL_PRE);
          end else if (i_loop) begin
            r_sel   <= SEL_FIRST;
            r_done  <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_sel   <= SEL_FIRST;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= SEL_FIRST;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sel  = r_sel;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/reg_scan_8x4.sv
// ============================================================================
// Module   : reg_scan_8x4
// Brief    : 8-entry register bank feeding an 8:1 mux, with scan sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_scan_8x4
  import reg_scan_8x4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             WrEn,
  input  logic [SEL_W-1:0] WrAddr,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic             Loop,
  input  logic             Stop,
  output logic [WIDTH-1:0] W0,
  output logic [WIDTH-1:0] W1,
  output logic [WIDTH-1:0] W2,
  output logic [WIDTH-1:0] W3,
  output logic [WIDTH-1:0] W4,
  output logic [WIDTH-1:0] W5,
  output logic [WIDTH-1:0] W6,
  output logic [WIDTH-1:0] W7,
  output logic             S2,
  output logic             S1,
  output logic             S0,
  output logic             Busy,
  output logic             Done
);

  logic [DEPTH-1:0] w_wr_hit;
  logic [WIDTH-1:0] w_entry [DEPTH];
  logic [SEL_W-1:0] w_sel;

  assign w_wr_hit = wr_decode(WrEn, WrAddr);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] r_val;

    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
        r_val <= '0;
      else if (w_wr_hit[gi])
        r_val <= D;
    end

    assign w_entry[gi] = r_val;
  end

  reg_scan_8x4_scan_ctrl u_scan_ctrl (
    .clk     (Clock),
    .rst_n   (Resetn),
    .i_start (Start),
    .i_loop  (Loop),
    .i_stop  (Stop),
    .o_sel   (w_sel),
    .o_busy  (Busy),
    .o_done  (Done)
  );

  // Entries go straight to the mux data pins with no output logic.
  assign W0 = w_entry[0];
  assign W1 = w_entry[1];
  assign W2 = w_entry[2];
  assign W3 = w_entry[3];
  assign W4 = w_entry[4];
  assign W5 = w_entry[5];
  assign W6 = w_entry[6];
  assign W7 = w_entry[7];

  assign {S2, S1, S0} = w_sel;

endmodule

`default_nettype wire

// File: tb/tb_reg_scan_8x4.sv
// ============================================================================
// Module   : tb_reg_scan_8x4
// Brief    : Randomized and directed bench against a behavioural scan model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_scan_8x4;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       WrEn;
  logic [2:0] WrAddr;
  logic [3:0] D;
  logic       Start, Loop, Stop;
  logic [3:0] W0, W1, W2, W3, W4, W5, W6, W7;
  logic       S2, S1, S0, Busy, Done;

  int checks = 0;
  int errors = 0;

  // Model: position in the scan (-1 = idle) and the register contents.
  int         m_pos;
  logic [3:0] m_mem [8];

  reg_scan_8x4 #(.WIDTH(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .D(D),
    .Start(Start), .Loop(Loop), .Stop(Stop),
    .W0(W0), .W1(W1), .W2(W2), .W3(W3), .W4(W4), .W5(W5), .W6(W6), .W7(W7),
    .S2(S2), .S1(S1), .S0(S0), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] mux_f();
    case ({S2, S1, S0})
      3'd0: return W0;  3'd1: return W1;  3'd2: return W2;  3'd3: return W3;
      3'd4: return W4;  3'd5: return W5;  3'd6: return W6;  default: return W7;
    endcase
  endfunction

  task automatic compare_all();
    int s;
    logic [31:0] exp_w;
    s = (m_pos < 0) ? 0 : m_pos;
    for (int i = 0; i < 8; i++) exp_w[i*4 +: 4] = m_mem[i];
    chk("sel",  {29'd0, S2, S1, S0}, s);
    chk("busy", {31'd0, Busy}, (m_pos >= 0) ? 1 : 0);
    chk("done", {31'd0, Done}, (m_pos == 7) ? 1 : 0);
    chk("f",    {28'd0, mux_f()}, {28'd0, m_mem[s]});
    chk("w",    {W7, W6, W5, W4, W3, W2, W1, W0}, exp_w);
  endtask

  task automatic drive(input logic we, input logic [2:0] a, input logic [3:0] d,
                       input logic st, input logic lp, input logic sp);
    WrEn = we; WrAddr = a; D = d; Start = st; Loop = lp; Stop = sp;
  endtask

  // One clock: model follows the rules at the edge, outputs checked 1ns later.
  task automatic step();
    @(posedge Clock);
    if (WrEn) m_mem[WrAddr] = D;
    if (m_pos < 0) begin
      if (Start && !Stop) m_pos = 0;
    end else if (Stop) m_pos = -1;
    else if (m_pos < 7) m_pos = m_pos + 1;
    else if (Loop) m_pos = 0;
    else m_pos = -1;
    #1;
    compare_all();
  endtask

  initial begin
    m_pos = -1;
    for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
    Resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    compare_all();
    Resetn = 1'b1;

    // Load 1..8 then a single pass.
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i), 4'(i + 1), 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();

    // Loop mode, drop Loop at SEL=3 of the second lap.
    drive(0, 0, 0, 1, 1, 0);
    step();
    Start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    Loop = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Abort at SEL=4.
    drive(0, 0, 0, 1, 0, 0);
    step();
    Start = 1'b0;
    while (m_pos != 4) step();
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    step();

    // Start and Stop together in IDLE.
    drive(0, 0, 0, 1, 0, 1);
    step();
    step();

    // Start held while scanning, plus write collision on the selected entry.
    drive(0, 0, 0, 1, 0, 0);
    step();
    for (int i = 0; i < 12; i++) begin
      if (m_pos == 2) drive(1, 3'd2, 4'hA, 1, 0, 0);
      else if (m_pos == 5) drive(1, 3'd1, 4'h5, 1, 0, 0);
      else drive(0, 0, 0, 1, 0, 0);
      step();
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0));
      step();
    end

    // Asynchronous reset in the middle of a scan with entries loaded.
    drive(1, 3'd3, 4'hF, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    step();
    step();
    #2 Resetn = 1'b0;
    #1;
    m_pos = -1;
    for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
    compare_all();
    #3 Resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
